// File: rtl/input_cond_pkg.sv
// rtl/input_cond_pkg.sv - shared types and width helpers for the input conditioner
//
// Contents:
//   edge_mode_e  - selects which accepted edges retrigger the pulse stretcher
//   count_width  - bit width of a counter that must hold the values 0..max_count

package input_cond_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;

    // The debounce counter only reaches DEBOUNCE_CYCLES-1, but the stretcher is
    // loaded with STRETCH_CYCLES itself, so both are sized for 0..max_count.
    function automatic int count_width(input int max_count);
        if (max_count < 1) begin
            return 1;
        end
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// rtl/input_conditioner_ch.sv - one conditioner channel: sync, debounce, edge pulses, stretcher
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active-low
//   in         in   raw asynchronous input
//   level      out  debounced level
//   rise       out  one-cycle pulse when level goes 0->1
//   fall       out  one-cycle pulse when level goes 1->0
//   stretch    out  high for STRETCH_CYCLES cycles after a selected edge
//   event_next out  combinational accept strobe; the top registers it so that
//                   any_event lines up with rise/fall

module input_conditioner_ch
    import input_cond_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter int         STRETCH_CYCLES  = 4,
    parameter edge_mode_e EDGE_MODE       = EDGE_RISE,
    parameter logic       INIT_LEVEL      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic stretch,
    output logic event_next
);

    localparam int CNT_W = count_width(DEBOUNCE_CYCLES);
    localparam int SC_W  = count_width(STRETCH_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SC_W-1:0]  SC_LOAD  = SC_W'(STRETCH_CYCLES);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic [SC_W-1:0]  sc;

    logic accept;
    logic rise_next;
    logic fall_next;
    logic stretch_load;

    // Accept once s2 has disagreed with level on DEBOUNCE_CYCLES consecutive
    // edges; cnt holds how many of those edges have already been seen.
    always_comb begin
        accept       = 1'b0;
        rise_next    = 1'b0;
        fall_next    = 1'b0;
        stretch_load = 1'b0;

        if ((s2 != level) && (cnt == CNT_LAST)) begin
            accept = 1'b1;
        end

        rise_next = accept & s2;
        fall_next = accept & ~s2;

        case (EDGE_MODE)
            EDGE_RISE: stretch_load = rise_next;
            EDGE_FALL: stretch_load = fall_next;
            default:   stretch_load = accept;
        endcase
    end

    assign event_next = accept;

    // Two-flop synchroniser; resets to the channel's idle level so a pad that
    // already sits at INIT_LEVEL produces no edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= INIT_LEVEL;
            s2 <= INIT_LEVEL;
        end else begin
            s1 <= in;
            s2 <= s1;
        end
    end

    // Debounce counter and accepted level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= INIT_LEVEL;
            cnt   <= '0;
        end else if (s2 == level) begin
            cnt <= '0;
        end else if (accept) begin
            level <= s2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Edge pulses are registered on the same edge as the level update, so
    // they are mutually exclusive and last exactly one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= rise_next;
            fall <= fall_next;
        end
    end

    // Retriggerable stretcher: a matching event reloads rather than queues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sc <= '0;
        end else if (stretch_load) begin
            sc <= SC_LOAD;
        end else if (sc != '0) begin
            sc <= sc - 1'b1;
        end
    end

    // Compare of a registered count: glitch-free, and rises with the pulse.
    assign stretch = (sc != '0);

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - multi-channel conditioner for asynchronous board inputs
//
// Ports:
//   clk        in   system clock (25 MHz domain)
//   rst        in   asynchronous reset, active-low
//   in         in   [CHANNELS] raw asynchronous inputs
//   level      out  [CHANNELS] debounced levels
//   rise       out  [CHANNELS] one-cycle 0->1 pulses
//   fall       out  [CHANNELS] one-cycle 1->0 pulses
//   stretch    out  [CHANNELS] stretched pulses on the selected edges
//   any_event  out  OR of all rise|fall bits, in the same cycle as those bits
//
// Reset release is expected to be synchronous to clk already; no release
// synchroniser is added here.

module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int                  CHANNELS        = 4,
    parameter int                  DEBOUNCE_CYCLES = 4,
    parameter int                  STRETCH_CYCLES  = 4,
    parameter edge_mode_e          EDGE_MODE       = EDGE_RISE,
    parameter logic [CHANNELS-1:0] INIT_LEVEL      = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] stretch,
    output logic                any_event
);

    logic [CHANNELS-1:0] event_next;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        input_conditioner_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .STRETCH_CYCLES  (STRETCH_CYCLES),
            .EDGE_MODE       (EDGE_MODE),
            .INIT_LEVEL      (INIT_LEVEL[i])
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .in         (in[i]),
            .level      (level[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .stretch    (stretch[i]),
            .event_next (event_next[i])
        );
    end

    // Registered from the channels' pre-register accept strobes so that it is
    // high in exactly the cycles where some rise or fall bit is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            any_event <= 1'b0;
        end else begin
            any_event <= |event_next;
        end
    end

endmodule
